// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: multi-cycle MSB-first magnitude comparator.
// Compares two WIDTH-bit operands DIGIT bits per clock, in unsigned or
// two's-complement mode. It can stop at the first differing digit, and it
// reports one-hot less/equal/greater flags plus the number of digit steps
// examined, through a start/busy/done handshake.
module seq_mag_comparator #(
   parameter int WIDTH      = 8,
   parameter int DIGIT      = 2,
   parameter bit EARLY_EXIT = 1'b1,
   localparam int N         = WIDTH / DIGIT,
   localparam int DW        = $clog2(N) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] Din_A,
   input  logic [WIDTH-1:0] Din_B,
   output logic             busy,
   output logic             done,
   output logic             less,
   output logic             equal,
   output logic             greater,
   output logic [DW-1:0]    digits
);

   // Counter width; kept at least one bit so the N = 1 case still elaborates.
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   // Sticky decision: set once at the first differing digit, then held.
   typedef enum logic [1:0] {
      DEC_NONE,
      DEC_LT,
      DEC_GT
   } dec_t;

   state_t           state_q, state_d;
   dec_t             dec_q, dec_d;
   logic [WIDTH-1:0] sa_q, sb_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] cap_a, cap_b;
   logic [DIGIT-1:0] dig_a, dig_b;
   logic             accept;
   logic             finish;
   logic             set_now;

   assign busy  = (state_q == RUN);
   assign dig_a = sa_q[WIDTH-1 -: DIGIT];
   assign dig_b = sb_q[WIDTH-1 -: DIGIT];

   // Operand capture: signed operands become offset-binary so the digit
   // compare below is always unsigned.
   always_comb begin
      cap_a = Din_A;
      cap_b = Din_B;
      if (signed_mode) begin
         cap_a[WIDTH-1] = ~Din_A[WIDTH-1];
         cap_b[WIDTH-1] = ~Din_B[WIDTH-1];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state, per-digit decision and finish detection.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      state_d = state_q;
      dec_d   = dec_q;
      accept  = 1'b0;
      finish  = 1'b0;
      set_now = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if ((dec_q == DEC_NONE) && (dig_a != dig_b)) begin
               set_now = 1'b1;
               dec_d   = (dig_a > dig_b) ? DEC_GT : DEC_LT;
            end
            if ((EARLY_EXIT && set_now) || (cnt_q == CW'(N - 1))) begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: shift registers, digit counter, decision and result registers.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the values from before the edge regardless of statement order.
      if (!rst_n) begin
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
         dec_q   <= DEC_NONE;
         done    <= 1'b0;
         less    <= 1'b0;
         equal   <= 1'b0;
         greater <= 1'b0;
         digits  <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            sa_q  <= cap_a;
            sb_q  <= cap_b;
            cnt_q <= '0;
            dec_q <= DEC_NONE;
         end else if (state_q == RUN) begin
            sa_q  <= sa_q << DIGIT;
            sb_q  <= sb_q << DIGIT;
            cnt_q <= cnt_q + CW'(1);
            dec_q <= dec_d;
            if (finish) begin
               done    <= 1'b1;
               less    <= (dec_d == DEC_LT);
               equal   <= (dec_d == DEC_NONE);
               greater <= (dec_d == DEC_GT);
               digits  <= DW'(cnt_q) + DW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Self-checking bench for seq_mag_comparator: one early-exit instance and one
// constant-latency instance, checked against an arithmetic reference model.
module tb_seq_mag_comparator;

   localparam int WIDTH = 8;
   localparam int DIGIT = 2;
   localparam int N     = WIDTH / DIGIT;
   localparam int DW    = $clog2(N) + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             start_ne = 1'b0;
   logic             signed_mode = 1'b0;
   logic [WIDTH-1:0] din_a = '0;
   logic [WIDTH-1:0] din_b = '0;

   logic             busy, done, less, equal, greater;
   logic [DW-1:0]    digits;
   logic             busy_ne, done_ne, less_ne, equal_ne, greater_ne;
   logic [DW-1:0]    digits_ne;

   int               tests = 0;
   int               fails = 0;
   logic [2:0]       prev_flags = 3'b000;

   seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
      .Din_A(din_a), .Din_B(din_b), .busy(busy), .done(done), .less(less),
      .equal(equal), .greater(greater), .digits(digits)
   );

   seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1'b0)) dut_ne (
      .clk(clk), .rst_n(rst_n), .start(start_ne), .signed_mode(signed_mode),
      .Din_A(din_a), .Din_B(din_b), .busy(busy_ne), .done(done_ne), .less(less_ne),
      .equal(equal_ne), .greater(greater_ne), .digits(digits_ne)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference flags {less, equal, greater} from integer values of the operands.
   function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic sm);
      int ia, ib;
      ia = int'(a);
      ib = int'(b);
      if (sm && a[WIDTH-1]) ia -= (1 << WIDTH);
      if (sm && b[WIDTH-1]) ib -= (1 << WIDTH);
      if (ia < ib)       return 3'b100;
      else if (ia == ib) return 3'b010;
      else               return 3'b001;
   endfunction

   // Early-exit step count: 1-based position of the first differing digit, or N.
   function automatic int ref_digits(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int x;
      x = int'(a ^ b);
      for (int i = 0; i < N; i++)
         if (((x >> (WIDTH - DIGIT * (i + 1))) & ((1 << DIGIT) - 1)) != 0) return i + 1;
      return N;
   endfunction

   // Wait for a done pulse on the early-exit instance; returns edges from the accept edge.
   task automatic wait_done(output int lat);
      lat = 0;
      for (int k = 1; k <= N + 2 && lat == 0; k++) begin
         @(posedge clk); #1;
         if (done) lat = k;
      end
   endtask

   // One compare on both instances; caller sits between edges.
   task automatic run_compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm);
      logic [2:0]    ef, f_ee, f_ne;
      int            ed, lat_ee, lat_ne;
      logic [DW-1:0] d_ee, d_ne;
      logic          b_ee, b_ne;
      ef = ref_flags(a, b, sm);
      ed = ref_digits(a, b);
      din_a = a; din_b = b; signed_mode = sm;
      start = 1'b1; start_ne = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; start_ne = 1'b0;
      din_a = WIDTH'($urandom); din_b = WIDTH'($urandom); signed_mode = 1'($urandom);
      check("busy_after_accept", busy, 1);
      check("busy_ne_after_accept", busy_ne, 1);
      check("flags_hold_in_run", {less, equal, greater}, prev_flags);
      lat_ee = 0; lat_ne = 0;
      f_ee = '0; f_ne = '0; d_ee = '0; d_ne = '0; b_ee = 1'b1; b_ne = 1'b1;
      for (int k = 1; k <= N + 2 && (lat_ee == 0 || lat_ne == 0); k++) begin
         @(posedge clk); #1;
         if (done && lat_ee == 0) begin
            lat_ee = k; f_ee = {less, equal, greater}; d_ee = digits; b_ee = busy;
         end
         if (done_ne && lat_ne == 0) begin
            lat_ne = k; f_ne = {less_ne, equal_ne, greater_ne}; d_ne = digits_ne; b_ne = busy_ne;
         end
      end
      check("latency_ee", lat_ee, ed);
      check("latency_ne", lat_ne, N);
      check("flags_ee", f_ee, ef);
      check("flags_ne", f_ne, ef);
      check("digits_ee", d_ee, ed);
      check("digits_ne", d_ne, N);
      check("busy_at_done_ee", b_ee, 0);
      check("busy_at_done_ne", b_ne, 0);
      @(posedge clk); #1;
      check("done_single_cycle_ee", done, 0);
      check("done_single_cycle_ne", done_ne, 0);
      check("flags_hold_after_done", {less, equal, greater}, ef);
      prev_flags = ef;
   endtask

   initial begin
      int lat;

      // Reset state of both instances.
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_flags", {less, equal, greater}, 3'b000);
      check("reset_digits", digits, 0);
      check("reset_flags_ne", {less_ne, equal_ne, greater_ne, busy_ne, done_ne}, 5'b00000);
      check("reset_digits_ne", digits_ne, 0);
      rst_n = 1'b1;

      // Directed cases from the test plan, plus range boundaries.
      run_compare(8'hA5, 8'hA7, 1'b0);
      run_compare(8'hF0, 8'h0F, 1'b0);
      run_compare(8'hF0, 8'h0F, 1'b1);
      run_compare(8'h3C, 8'h3C, 1'b0);
      run_compare(8'h00, 8'hFF, 1'b0);
      run_compare(8'h00, 8'hFF, 1'b1);
      run_compare(8'h80, 8'h7F, 1'b1);
      run_compare(8'h7F, 8'h80, 1'b0);
      run_compare(8'hFF, 8'hFF, 1'b1);

      // Random pairs in both modes.
      for (int i = 0; i < 300; i++)
         run_compare(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));

      // Handshake: start held through RUN with new operands is ignored.
      din_a = 8'h55; din_b = 8'h56; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      din_a = 8'hFF; din_b = 8'h00; signed_mode = 1'b1;
      wait_done(lat);
      check("hs_ignore_latency", lat, N);
      check("hs_ignore_flags", {less, equal, greater}, ref_flags(8'h55, 8'h56, 1'b0));
      check("hs_ignore_digits", digits, N);
      // Start still high in the done cycle: the next compare begins with no gap.
      din_a = 8'h12; din_b = 8'h34; signed_mode = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_busy", busy, 1);
      check("b2b_done_low", done, 0);
      wait_done(lat);
      check("b2b_latency", lat, ref_digits(8'h12, 8'h34));
      check("b2b_flags", {less, equal, greater}, ref_flags(8'h12, 8'h34, 1'b0));
      check("b2b_digits", digits, ref_digits(8'h12, 8'h34));
      prev_flags = ref_flags(8'h12, 8'h34, 1'b0);
      @(posedge clk); #1;

      // Reset at E2 of an equal compare aborts it with no done pulse.
      din_a = 8'h3C; din_b = 8'h3C; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_flags", {less, equal, greater}, 3'b000);
      check("abort_digits", digits, 0);
      rst_n = 1'b1;
      for (int k = 0; k < N + 1; k++) begin
         @(posedge clk); #1;
         check("abort_no_done", done, 0);
      end
      prev_flags = 3'b000;
      run_compare(8'h10, 8'h10, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
